clint: RTL and testbench

Core-local interrupt controller: the sole sequencer of the CSR file's secondary write port. Detects synchronous traps (ecall/ebreak), mret and enabled external/timer interrupts. Stalls the pipeline, performs the trap-entry or trap-return CSR write sequence, then redirects fetch. The CSR file's execute-stage write port has priority over this block; the controller retries any write step that collides with it.

---
 rtl/clint.sv | 155 +++++++++++++++
 tb/tb_clint.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interrupt controller: sequences trap-entry / trap-return CSR writes
// on the CSR file's secondary port, then issues a one-cycle fetch redirect.
module clint #(
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0007,
  parameter int          INT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic              ex_csr_we_i,
  input  logic [31:0]       csr_mtvec_i,
  input  logic [31:0]       csr_mepc_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic              global_int_en_i,
  output logic              hold_flag_o,
  output logic              we_o,
  output logic [31:0]       waddr_o,
  output logic [31:0]       wdata_o,
  output logic              int_assert_o,
  output logic [31:0]       int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_ASSERT,
    S_R_MSTATUS,
    S_R_ASSERT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;

  logic is_ecall, is_ebreak, is_mret, is_async;
  logic sync_trap, trigger;
  logic [31:0] mstatus_entry, mstatus_return;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign is_async  = (|int_flag_i) & global_int_en_i;
  assign sync_trap = is_ecall | is_ebreak;
  assign trigger   = (state_reg == S_IDLE) & (sync_trap | is_mret | is_async);

  // Entry stacks MIE into MPIE and disables interrupts; return restores MIE and sets MPIE.
  always_comb begin
    mstatus_entry     = csr_mstatus_i;
    mstatus_entry[7]  = csr_mstatus_i[3];
    mstatus_entry[3]  = 1'b0;
    mstatus_return    = csr_mstatus_i;
    mstatus_return[3] = csr_mstatus_i[7];
    mstatus_return[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cause_reg <= '0;
      epc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      epc_reg   <= epc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    epc_next   = epc_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (sync_trap) begin
          state_next = S_W_MEPC;
          cause_next = is_ecall ? 32'd11 : 32'd3;
          epc_next   = inst_addr_i;
        end else if (is_mret) begin
          state_next = S_R_MSTATUS;
        end else if (is_async) begin
          state_next = S_W_MEPC;
          cause_next = ASYNC_CAUSE;
          epc_next   = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      // A write colliding with the execute-stage port is lost, so the step repeats.
      S_W_MEPC:    if (!ex_csr_we_i) state_next = S_W_MSTATUS;
      S_W_MSTATUS: if (!ex_csr_we_i) state_next = S_W_MCAUSE;
      S_W_MCAUSE:  if (!ex_csr_we_i) state_next = S_ASSERT;
      S_R_MSTATUS: if (!ex_csr_we_i) state_next = S_R_ASSERT;
      S_ASSERT:    state_next = S_IDLE;
      S_R_ASSERT:  state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight write is not issued.
  always_comb begin
    hold_flag_o  = 1'b0;
    we_o         = 1'b0;
    waddr_o      = '0;
    wdata_o      = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    if (!rst) begin
      hold_flag_o = (state_reg != S_IDLE) | trigger;
      unique case (state_reg)
        S_W_MEPC: begin
          we_o    = 1'b1;
          waddr_o = CSR_MEPC;
          wdata_o = epc_reg;
        end
        S_W_MSTATUS: begin
          we_o    = 1'b1;
          waddr_o = CSR_MSTATUS;
          wdata_o = mstatus_entry;
        end
        S_W_MCAUSE: begin
          we_o    = 1'b1;
          waddr_o = CSR_MCAUSE;
          wdata_o = cause_reg;
        end
        S_R_MSTATUS: begin
          we_o    = 1'b1;
          waddr_o = CSR_MSTATUS;
          wdata_o = mstatus_return;
        end
        S_ASSERT: begin
          int_assert_o = 1'b1;
          int_addr_o   = csr_mtvec_i;
        end
        S_R_ASSERT: begin
          int_assert_o = 1'b1;
          int_addr_o   = csr_mepc_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint: trap entry, async entry, collisions,
// mret, priority and mid-sequence reset with hand-computed expectations.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i;
  logic [7:0]  int_flag_i;
  logic        ex_csr_we_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        global_int_en_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clint #(.ASYNC_CAUSE(32'h8000_0007), .INT_W(8)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .int_flag_i(int_flag_i), .ex_csr_we_i(ex_csr_we_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .global_int_en_i(global_int_en_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sample all outputs mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic h, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd,
                     input logic ia, input logic [31:0] iaddr);
    @(negedge clk);
    check({tag, ".hold"},   {31'd0, hold_flag_o},  {31'd0, h});
    check({tag, ".we"},     {31'd0, we_o},         {31'd0, we});
    check({tag, ".waddr"},  waddr_o,               wa);
    check({tag, ".wdata"},  wdata_o,               wd);
    check({tag, ".assert"}, {31'd0, int_assert_o}, {31'd0, ia});
    check({tag, ".iaddr"},  int_addr_o,            iaddr);
    @(posedge clk);
    #1;
  endtask

  // Trigger cycle T through the first idle cycle after the assert, no collisions.
  task automatic run_entry(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] mst_wr, input logic [31:0] mtvec);
    cyc({tag, ".T"}, 1, 0, 0, 0, 0, 0);
    inst_i     = 32'h0000_0013;
    int_flag_i = 8'h00;
    cyc({tag, ".T1"}, 1, 1, 32'h341, epc, 0, 0);
    cyc({tag, ".T2"}, 1, 1, 32'h300, mst_wr, 0, 0);
    cyc({tag, ".T3"}, 1, 1, 32'h342, cause, 0, 0);
    cyc({tag, ".T4"}, 1, 0, 0, 0, 1, mtvec);
    cyc({tag, ".T5"}, 0, 0, 0, 0, 0, 0);
    $display("txn %s: epc=0x%08h cause=0x%08h vector=0x%08h", tag, epc, cause, mtvec);
  endtask

  initial begin
    rst = 1; inst_i = 32'h0000_0013; inst_addr_i = 32'h100; jump_flag_i = 0; jump_addr_i = 0;
    int_flag_i = 8'h01; global_int_en_i = 1; ex_csr_we_i = 0;
    csr_mtvec_i = 32'h200; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h8;
    #1;
    cyc("rst0", 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0, 0);
    int_flag_i = 0;
    rst = 0;
    cyc("idle", 0, 0, 0, 0, 0, 0);
    $display("txn reset: outputs quiet");

    inst_i = 32'h0000_0073;
    run_entry("ecall", 32'h100, 32'd11, 32'h80, 32'h200);

    int_flag_i = 8'h01; jump_flag_i = 1; jump_addr_i = 32'h340;
    run_entry("async", 32'h340, 32'h8000_0007, 32'h80, 32'h200);
    jump_flag_i = 0;

    global_int_en_i = 0; int_flag_i = 8'h01;
    cyc("masked0", 0, 0, 0, 0, 0, 0);
    cyc("masked1", 0, 0, 0, 0, 0, 0);
    int_flag_i = 0; global_int_en_i = 1;
    $display("txn masked: no trigger");

    inst_i = 32'h0010_0073; inst_addr_i = 32'h180;
    run_entry("ebreak", 32'h180, 32'd3, 32'h80, 32'h200);

    inst_i = 32'h0000_0073; inst_addr_i = 32'h100;
    cyc("coll.T", 1, 0, 0, 0, 0, 0);
    inst_i = 32'h0000_0013; ex_csr_we_i = 1;
    cyc("coll.T1", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc("coll.T2", 1, 1, 32'h341, 32'h100, 0, 0);
    ex_csr_we_i = 0;
    cyc("coll.T3", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc("coll.T4", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("coll.T5", 1, 1, 32'h342, 32'd11, 0, 0);
    cyc("coll.T6", 1, 0, 0, 0, 1, 32'h200);
    cyc("coll.T7", 0, 0, 0, 0, 0, 0);
    $display("txn collision: assert after two retried cycles");

    inst_i = 32'h3020_0073; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    cyc("mret.T", 1, 0, 0, 0, 0, 0);
    inst_i = 32'h0000_0013;
    cyc("mret.T1", 1, 1, 32'h300, 32'h88, 0, 0);
    cyc("mret.T2", 1, 0, 0, 0, 1, 32'h104);
    cyc("mret.T3", 0, 0, 0, 0, 0, 0);
    $display("txn mret: return to 0x104");

    csr_mstatus_i = 32'h8; inst_i = 32'h0000_0073; int_flag_i = 8'hFF;
    run_entry("prio", 32'h100, 32'd11, 32'h80, 32'h200);

    inst_i = 32'h0000_0073; inst_addr_i = 32'h1F0;
    cyc("rmid.T", 1, 0, 0, 0, 0, 0);
    inst_i = 32'h0000_0013;
    cyc("rmid.T1", 1, 1, 32'h341, 32'h1F0, 0, 0);
    rst = 1;
    cyc("rmid.T2", 0, 0, 0, 0, 0, 0);
    rst = 0;
    cyc("rmid.T3", 0, 0, 0, 0, 0, 0);
    cyc("rmid.T4", 0, 0, 0, 0, 0, 0);
    $display("txn reset-mid: sequence aborted after mepc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
